// File: rtl/sad_accumulator.sv
// SAD accumulator: per-macroblock 4x4/16x16 sums of absolute differences, clamped to 12 bits,
// with raster block position tracking. Optional saturation flags under `SAD_SAT_FLAG_EN`.
module sad_accumulator #(
  parameter int WIDTH     = 1280,
  parameter int LENGTH    = 720,
  parameter int MB_SIZE_L = 8,
  parameter int MB_SIZE_W = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       pix_valid,
  input  logic [7:0]                                 orig,
  input  logic [7:0]                                 pred_4x4,
  input  logic [7:0]                                 pred_16x16,
  output logic [11:0]                                sum_4x4,
  output logic [11:0]                                sum_16x16,
  output logic                                       sum_valid,
  output logic [$clog2(WIDTH/MB_SIZE_W)-1:0]         mb_x,
  output logic [$clog2(LENGTH/MB_SIZE_L)-1:0]        mb_y,
  output logic                                       frame_done
`ifdef SAD_SAT_FLAG_EN
  ,
  output logic                                       sat_4x4,
  output logic                                       sat_16x16
`endif
);

  localparam int N       = MB_SIZE_L * MB_SIZE_W;
  localparam int MBX     = WIDTH / MB_SIZE_W;
  localparam int MBY     = LENGTH / MB_SIZE_L;
  localparam int ACC_W   = $clog2(N * 255 + 1);
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int XW      = $clog2(MBX);
  localparam int YW      = $clog2(MBY);
  localparam int SUM_MAX = 4095;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc_4x4, acc_16x16;
  logic [ACC_W-1:0]  acc_next_4x4, acc_next_16x16;
  logic [XW-1:0]     pos_x;
  logic [YW-1:0]     pos_y;
  logic signed [8:0] diff_4x4, diff_16x16;
  logic [7:0]        d_4x4, d_16x16;
  logic              last_pix, pos_x_end, pos_y_end;

  function automatic logic [11:0] clamp12(input logic [ACC_W-1:0] v);
    return (32'(v) > SUM_MAX) ? 12'(SUM_MAX) : 12'(v);
  endfunction

  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    diff_4x4       = $signed({1'b0, orig}) - $signed({1'b0, pred_4x4});
    diff_16x16     = $signed({1'b0, orig}) - $signed({1'b0, pred_16x16});
    d_4x4          = diff_4x4[8]   ? 8'(-diff_4x4)   : diff_4x4[7:0];
    d_16x16        = diff_16x16[8] ? 8'(-diff_16x16) : diff_16x16[7:0];
    // The first pixel of a block loads rather than adds.
    acc_next_4x4   = ((state == IDLE) ? '0 : acc_4x4)   + ACC_W'(d_4x4);
    acc_next_16x16 = ((state == IDLE) ? '0 : acc_16x16) + ACC_W'(d_16x16);
    last_pix       = (cnt == CNT_W'(N - 1));
    pos_x_end      = (pos_x == XW'(MBX - 1));
    pos_y_end      = (pos_y == YW'(MBY - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset branch covers every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_4x4    <= '0;
      acc_16x16  <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      sum_4x4    <= '0;
      sum_16x16  <= '0;
      sum_valid  <= 1'b0;
      mb_x       <= '0;
      mb_y       <= '0;
      frame_done <= 1'b0;
`ifdef SAD_SAT_FLAG_EN
      sat_4x4    <= 1'b0;
      sat_16x16  <= 1'b0;
`endif
    end else begin
      sum_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        if (last_pix) begin
          sum_4x4    <= clamp12(acc_next_4x4);
          sum_16x16  <= clamp12(acc_next_16x16);
`ifdef SAD_SAT_FLAG_EN
          sat_4x4    <= (32'(acc_next_4x4) > SUM_MAX);
          sat_16x16  <= (32'(acc_next_16x16) > SUM_MAX);
`endif
          sum_valid  <= 1'b1;
          mb_x       <= pos_x;
          mb_y       <= pos_y;
          frame_done <= pos_x_end && pos_y_end;
          acc_4x4    <= '0;
          acc_16x16  <= '0;
          cnt        <= '0;
          state      <= IDLE;
          if (pos_x_end) begin
            pos_x <= '0;
            pos_y <= pos_y_end ? '0 : pos_y + YW'(1);
          end else begin
            pos_x <= pos_x + XW'(1);
          end
        end else begin
          acc_4x4    <= acc_next_4x4;
          acc_16x16  <= acc_next_16x16;
          cnt        <= cnt + CNT_W'(1);
          state      <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_accumulator.sv
// Directed, table-driven bench for sad_accumulator: an 8x8-block DUT on a 5x3-block frame
// plus a 1x1-block DUT on a 4x2 frame.
module tb_sad_accumulator;

  localparam int WIDTH  = 40;
  localparam int LENGTH = 24;
  localparam int MBX    = 5;
  localparam int MBY    = 3;
  localparam int N      = 64;
  localparam int XW     = $clog2(MBX);
  localparam int YW     = $clog2(MBY);

  logic clk = 1'b0;
  logic rst, pix_valid;
  logic [7:0] orig, pred_4x4, pred_16x16;

  logic [11:0]   sum_4x4, sum_16x16;
  logic          sum_valid, frame_done;
  logic [XW-1:0] mb_x;
  logic [YW-1:0] mb_y;
`ifdef SAD_SAT_FLAG_EN
  logic          sat_4x4, sat_16x16;
  logic          n1_sat_4x4, n1_sat_16x16;
`endif

  logic [11:0] n1_sum_4x4, n1_sum_16x16;
  logic        n1_sum_valid, n1_frame_done;
  logic [1:0]  n1_mb_x;
  logic [0:0]  n1_mb_y;

  int errors = 0;
  int checks = 0;
  int exp_x  = 0;
  int exp_y  = 0;

  sad_accumulator #(.WIDTH(WIDTH), .LENGTH(LENGTH), .MB_SIZE_L(8), .MB_SIZE_W(8)) u_dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid),
    .orig(orig), .pred_4x4(pred_4x4), .pred_16x16(pred_16x16),
    .sum_4x4(sum_4x4), .sum_16x16(sum_16x16), .sum_valid(sum_valid),
    .mb_x(mb_x), .mb_y(mb_y), .frame_done(frame_done)
`ifdef SAD_SAT_FLAG_EN
    , .sat_4x4(sat_4x4), .sat_16x16(sat_16x16)
`endif
  );

  sad_accumulator #(.WIDTH(4), .LENGTH(2), .MB_SIZE_L(1), .MB_SIZE_W(1)) u_dut_n1 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid),
    .orig(orig), .pred_4x4(pred_4x4), .pred_16x16(pred_16x16),
    .sum_4x4(n1_sum_4x4), .sum_16x16(n1_sum_16x16), .sum_valid(n1_sum_valid),
    .mb_x(n1_mb_x), .mb_y(n1_mb_y), .frame_done(n1_frame_done)
`ifdef SAD_SAT_FLAG_EN
    , .sat_4x4(n1_sat_4x4), .sat_16x16(n1_sat_16x16)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] o, p4, p16;
    int         s4, s16;
    logic       sat4, sat16;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic drive(input logic v, input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    pix_valid  = v;
    orig       = o;
    pred_4x4   = a;
    pred_16x16 = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_x = 0;
    exp_y = 0;
  endtask

  task automatic check_block(input string name, input int e4, input int e16,
                             input logic es4, input logic es16);
    check({name, " sum_valid"},  32'(sum_valid), 1);
    check({name, " sum_4x4"},    32'(sum_4x4), e4);
    check({name, " sum_16x16"},  32'(sum_16x16), e16);
    check({name, " mb_x"},       32'(mb_x), exp_x);
    check({name, " mb_y"},       32'(mb_y), exp_y);
    check({name, " frame_done"}, 32'(frame_done), (exp_x == MBX-1 && exp_y == MBY-1) ? 1 : 0);
`ifdef SAD_SAT_FLAG_EN
    check({name, " sat_4x4"},    32'(sat_4x4), 32'(es4));
    check({name, " sat_16x16"},  32'(sat_16x16), 32'(es16));
`else
    if (es4 === 1'bx || es16 === 1'bx) $display("unexpected X in expected sat flags");
`endif
    if (exp_x == MBX-1) begin
      exp_x = 0;
      exp_y = (exp_y == MBY-1) ? 0 : exp_y + 1;
    end else begin
      exp_x++;
    end
  endtask

  initial begin
    int pulses, first_c, second_c, fd_count;

    vecs[0] = '{o:100, p4:100, p16:90,  s4:0,    s16:640,  sat4:0, sat16:0};
    vecs[1] = '{o:255, p4:0,   p16:200, s4:4095, s16:3520, sat4:1, sat16:0};
    vecs[2] = '{o:0,   p4:255, p16:255, s4:4095, s16:4095, sat4:1, sat16:1};
    vecs[3] = '{o:10,  p4:20,  p16:5,   s4:640,  s16:320,  sat4:0, sat16:0};
    vecs[4] = '{o:64,  p4:0,   p16:0,   s4:4095, s16:4095, sat4:1, sat16:1};
    vecs[5] = '{o:63,  p4:0,   p16:127, s4:4032, s16:4095, sat4:0, sat16:1};
    vecs[6] = '{o:7,   p4:7,   p16:7,   s4:0,    s16:0,    sat4:0, sat16:0};

    rst = 1'b1; pix_valid = 1'b0; orig = '0; pred_4x4 = '0; pred_16x16 = '0;
    repeat (3) @(negedge clk);
    check("reset sum_valid",  32'(sum_valid), 0);
    check("reset sum_4x4",    32'(sum_4x4), 0);
    check("reset sum_16x16",  32'(sum_16x16), 0);
    check("reset mb_x",       32'(mb_x), 0);
    check("reset mb_y",       32'(mb_y), 0);
    check("reset frame_done", 32'(frame_done), 0);
`ifdef SAD_SAT_FLAG_EN
    check("reset sat_4x4",    32'(sat_4x4), 0);
    check("reset sat_16x16",  32'(sat_16x16), 0);
`endif
    rst = 1'b0;

    // One-pixel blocks: every accepted pixel completes a block.
    for (int i = 0; i <= 8; i++) begin
      drive(i < 8, 8'd200, 8'(50 + i), 8'(210 + i));
      if (i > 0) begin
        check($sformatf("n1 px%0d sum_valid", i-1),  32'(n1_sum_valid), 1);
        check($sformatf("n1 px%0d sum_4x4", i-1),    32'(n1_sum_4x4), 150 - (i-1));
        check($sformatf("n1 px%0d sum_16x16", i-1),  32'(n1_sum_16x16), 10 + (i-1));
        check($sformatf("n1 px%0d mb_x", i-1),       32'(n1_mb_x), (i-1) % 4);
        check($sformatf("n1 px%0d mb_y", i-1),       32'(n1_mb_y), (i-1) / 4);
        check($sformatf("n1 px%0d frame_done", i-1), 32'(n1_frame_done), (i-1 == 7) ? 1 : 0);
      end
    end
    do_reset();

    // Table of uniform full blocks, one gap cycle between blocks.
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < N; i++) drive(1'b1, vecs[k].o, vecs[k].p4, vecs[k].p16);
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      check_block($sformatf("vec%0d", k), vecs[k].s4, vecs[k].s16, vecs[k].sat4, vecs[k].sat16);
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      check($sformatf("vec%0d pulse end", k), 32'(sum_valid), 0);
      check($sformatf("vec%0d hold", k),      32'(sum_4x4), vecs[k].s4);
    end

    // Raw sum of exactly 4095 is not saturated.
    for (int i = 0; i < N-1; i++) drive(1'b1, 8'd64, 8'd0, 8'd0);
    drive(1'b1, 8'd63, 8'd0, 8'd1);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check_block("exact4095", 4095, 4094, 1'b0, 1'b0);

    // Two blocks back to back with continuous pix_valid.
    pulses = 0; first_c = -1; second_c = -1;
    for (int c = 0; c < 130; c++) begin
      if (c < 64)       drive(1'b1, 8'd100, 8'd101, 8'd99);
      else if (c < 128) drive(1'b1, 8'd100, 8'd102, 8'd98);
      else              drive(1'b0, 8'd0, 8'd0, 8'd0);
      if (sum_valid) begin
        pulses++;
        if (pulses == 1) begin first_c = c;  check_block("b2b first", 64, 64, 1'b0, 1'b0); end
        else begin second_c = c; check_block("b2b second", 128, 128, 1'b0, 1'b0); end
      end
    end
    check("b2b pulses", pulses, 2);
    check("b2b first cycle", first_c, 64);
    check("b2b spacing", second_c - first_c, 64);

    // pix_valid toggling: 64 accepted pixels over 128 cycles.
    pulses = 0; first_c = -1;
    for (int c = 0; c < 130; c++) begin
      drive((c < 128) && (c % 2 == 0), 8'd100, 8'd103, 8'd97);
      if (sum_valid) begin
        pulses++;
        first_c = c;
        check_block("gaps", 192, 192, 1'b0, 1'b0);
      end
    end
    check("gaps pulses", pulses, 1);
    check("gaps cycle", first_c, 127);

    // Reset mid-block, asserted alongside a valid pixel.
    for (int i = 0; i < 30; i++) drive(1'b1, 8'd100, 8'd101, 8'd99);
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; pix_valid = 1'b0;
    exp_x = 0; exp_y = 0;
    check("midrst sum_valid", 32'(sum_valid), 0);
    check("midrst sum_4x4",   32'(sum_4x4), 0);
    check("midrst mb_x",      32'(mb_x), 0);
    pulses = 0;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 8'd100, 8'd101, 8'd99);
      if (sum_valid) pulses++;
    end
    check("midrst no early pulse", pulses, 0);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check_block("midrst block", 64, 64, 1'b0, 1'b0);

    // Full frame plus one block, continuous stream.
    do_reset();
    pulses = 0; fd_count = 0;
    for (int c = 0; c <= (MBX*MBY + 1) * N; c++) begin
      drive(c < (MBX*MBY + 1) * N, 8'd50, 8'd50, 8'd50);
      if (frame_done) fd_count++;
      if (sum_valid) begin
        pulses++;
        check_block($sformatf("frame blk%0d", pulses-1), 0, 0, 1'b0, 1'b0);
      end
    end
    check("frame blocks", pulses, MBX*MBY + 1);
    check("frame_done count", fd_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
